regfile_writer: RTL

Write side of the 32 x 32-bit register file. Owns the storage array, decodes a 5-bit write address into one-hot register enables, and runs a scrub state machine that zeroes the file one register per cycle after reset or on request. All 32 registers are exported as a flat bus that feeds the read-side 32:1 word multiplexers.

---
 rtl/regfile_writer_pkg.sv | 32 +++
 rtl/regfile_writer_if.sv | 28 ++
 rtl/regfile_writer_decoder_32.sv | 18 +
 rtl/regfile_writer.sv | 116 +++++++++++
 4 files changed

// File: rtl/regfile_writer_pkg.sv
// rtl/regfile_writer_pkg.sv - shared constants, state enum and regs_out slicing helper
package regfile_writer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;
  localparam int NUM_REGS   = 32;

  // SCRUB zeroes the file one register per cycle; READY accepts writes.
  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } state_e;

  typedef logic [NUM_REGS*REG_W-1:0] regs_flat_t;
  typedef logic [REG_W-1:0]          reg_word_t;
  typedef logic [REG_ADDR_W-1:0]     reg_addr_t;

  // Pulls register idx out of the flat regs_out bus (word i at [i*REG_W +: REG_W]).
  function automatic reg_word_t regs_word(input regs_flat_t flat, input reg_addr_t idx);
    return flat[int'(idx)*REG_W +: REG_W];
  endfunction

  // Places one word into a flat bus image; the read side builds test images with it.
  function automatic regs_flat_t regs_put(input regs_flat_t flat, input reg_addr_t idx,
                                          input reg_word_t word);
    regs_flat_t res;
    res = flat;
    res[int'(idx)*REG_W +: REG_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/regfile_writer_if.sv
// rtl/regfile_writer_if.sv - write-port handshake bundle for the register file
interface regfile_writer_if
  import regfile_writer_pkg::*;
#(
  parameter int WIDTH = REG_W
) ();

  logic             wr_valid;
  logic             wr_ready;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;

  // Requester drives the write; the register file answers with wr_ready.
  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/regfile_writer_decoder_32.sv
// rtl/regfile_writer_decoder_32.sv - 5-bit address to 32-bit one-hot enable decoder
module decoder_32
  import regfile_writer_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   onehot
);

  // One-hot select of addr, all zero when not enabled.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - write side of the 32x32 register file with scrub state machine
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter int NREGS = NUM_REGS,
  parameter int WIDTH = REG_W
) (
  input  logic                   clock,
  input  logic                   reset,
  regfile_writer_if.slave        wr_if,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   clear_done,
  output logic [NREGS*WIDTH-1:0] regs_out
);

  localparam logic [REG_ADDR_W-1:0] PTR_FIRST = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] PTR_LAST  = REG_ADDR_W'(NREGS - 1);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  clear_done_q, clear_done_d;

  logic                  wr_fire;
  logic                  scrub_en;
  logic [NUM_REGS-1:0]   wr_onehot;
  logic [NUM_REGS-1:0]   scrub_onehot;
  logic [NUM_REGS-1:0]   mem_we;
  logic [WIDTH-1:0]      mem_d;

  // Register 0 is hardwired to zero, so the array starts at index 1.
  logic [WIDTH-1:0]      mem_q [1:NREGS-1];

  logic                  unused_mem_we0;

  // Next-state logic: walk ptr through 1..31 while scrubbing, restart on clear_req in READY.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    clear_done_d = 1'b0;
    if (state_q == SCRUB) begin
      ptr_d = ptr_q + REG_ADDR_W'(1);
      if (ptr_q == PTR_LAST) begin
        state_d      = READY;
        clear_done_d = 1'b1;
      end
    end else begin
      if (clear_req) begin
        state_d = SCRUB;
        ptr_d   = PTR_FIRST;
      end
    end
  end

  // Control state register; reset restarts the scrub but leaves the storage alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SCRUB;
      ptr_q        <= PTR_FIRST;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign busy           = (state_q == SCRUB);
  assign wr_if.wr_ready = (state_q == READY);
  assign clear_done     = clear_done_q;

  // A cycle with reset high drops any write or scrub step into the array.
  assign wr_fire  = wr_if.wr_valid && wr_if.wr_ready && !reset;
  assign scrub_en = busy && !reset;

  decoder_32 u_wr_dec (
    .addr   (wr_if.wr_addr),
    .en     (wr_fire),
    .onehot (wr_onehot)
  );

  decoder_32 u_scrub_dec (
    .addr   (ptr_q),
    .en     (scrub_en),
    .onehot (scrub_onehot)
  );

  // Merge the two enable sources; the two paths are exclusive by state, so data follows busy.
  always_comb begin
    mem_we = wr_onehot | scrub_onehot;
    mem_d  = '0;
    if (!busy) begin
      mem_d = WIDTH'(wr_if.wr_data);
    end
  end

  assign unused_mem_we0 = mem_we[0];

  // Storage array, no reset so it stays RAM-inferable.
  always_ff @(posedge clock) begin
    for (int i = 1; i < NREGS; i++) begin
      if (mem_we[i]) begin
        mem_q[i] <= mem_d;
      end
    end
  end

  // Flatten the file for the read-side muxes; word 0 is constant zero.
  always_comb begin
    regs_out = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_out[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

endmodule
